// File: rtl/bp_me_nonsynth_lce_tr_replay.sv
// Trace-replay engine for one LCE: steps through a combinational trace ROM,
// issues TR command packets and checks returned TR response packets.
module bp_me_nonsynth_lce_tr_replay #(
    parameter int paddr_width_p    = 40,
    parameter int dword_width_p    = 64,
    parameter int rom_addr_width_p = 10,
    parameter int timeout_p        = 1024,
    localparam int tr_pkt_width_lp   = 5 + paddr_width_p + dword_width_p,
    localparam int rom_data_width_lp = 4 + tr_pkt_width_lp
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    output logic [rom_addr_width_p-1:0]  rom_addr_o,
    input  logic [rom_data_width_lp-1:0] rom_data_i,
    output logic [tr_pkt_width_lp-1:0]   tr_pkt_o,
    output logic                         tr_pkt_v_o,
    input  logic                         tr_pkt_yumi_i,
    input  logic [tr_pkt_width_lp-1:0]   tr_pkt_i,
    input  logic                         tr_pkt_v_i,
    output logic                         tr_pkt_ready_o,
    output logic                         done_o,
    output logic                         error_o,
    output logic                         timeout_o,
    output logic [15:0]                  mismatch_count_o
);

    localparam int TMO_W = ($clog2(timeout_p) > 0) ? $clog2(timeout_p) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(timeout_p - 1);

    localparam logic [3:0] OP_SEND = 4'h1;
    localparam logic [3:0] OP_RECV = 4'h2;
    localparam logic [3:0] OP_WAIT = 4'h3;
    localparam logic [3:0] OP_DONE = 4'h4;

    typedef enum logic [2:0] {
        S_FETCH,
        S_SEND,
        S_RECV,
        S_WAIT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e r_state;
    state_e w_state_nxt;

    logic [rom_addr_width_p-1:0] r_addr;
    logic [tr_pkt_width_lp-1:0]  r_pkt;
    logic [TMO_W-1:0]            r_tmo;
    logic [15:0]                 r_wait;
    logic                        r_error;
    logic                        r_timeout;
    logic [15:0]                 r_mcount;

    logic [3:0]                  w_op;
    logic [tr_pkt_width_lp-1:0]  w_rom_pkt;
    logic                        w_addr_last;
    logic                        w_step;
    logic                        w_rsp_hs;
    logic                        w_mismatch;

    assign w_op        = rom_data_i[rom_data_width_lp-1 -: 4];
    assign w_rom_pkt   = rom_data_i[tr_pkt_width_lp-1:0];
    assign w_addr_last = &r_addr;
    assign w_rsp_hs    = (r_state == S_RECV) && tr_pkt_v_i;

    // Header (cmd, uncached, paddr) always compared; data only when the expected cmd is a load.
    assign w_mismatch =
        (tr_pkt_i[tr_pkt_width_lp-1:dword_width_p] != r_pkt[tr_pkt_width_lp-1:dword_width_p]) ||
        (!r_pkt[tr_pkt_width_lp-1] && (tr_pkt_i[dword_width_p-1:0] != r_pkt[dword_width_p-1:0]));

    always_comb begin
        w_step = 1'b0;
        case (r_state)
            S_SEND:  w_step = tr_pkt_yumi_i;
            S_RECV:  w_step = tr_pkt_v_i;
            S_WAIT:  w_step = (r_wait == 16'd0);
            default: w_step = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (en_i) begin
                    case (w_op)
                        OP_SEND: w_state_nxt = S_SEND;
                        OP_RECV: w_state_nxt = S_RECV;
                        OP_WAIT: w_state_nxt = S_WAIT;
                        OP_DONE: w_state_nxt = S_DONE;
                        default: w_state_nxt = S_ERROR;
                    endcase
                end
            end
            S_SEND, S_WAIT: begin
                if (w_step) begin
                    w_state_nxt = w_addr_last ? S_ERROR : S_FETCH;
                end
            end
            S_RECV: begin
                // A response in the final timeout cycle wins over the timeout.
                if (tr_pkt_v_i) begin
                    w_state_nxt = w_addr_last ? S_ERROR : S_FETCH;
                end else if (r_tmo == TMO_LAST) begin
                    w_state_nxt = S_ERROR;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERROR: w_state_nxt = S_ERROR;
            default: w_state_nxt = S_ERROR;
        endcase
    end

    // Datapath and sticky status
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_addr    <= '0;
            r_pkt     <= '0;
            r_tmo     <= '0;
            r_wait    <= '0;
            r_error   <= 1'b0;
            r_timeout <= 1'b0;
            r_mcount  <= '0;
        end else begin
            if ((r_state == S_FETCH) && en_i) begin
                if ((w_op == OP_SEND) || (w_op == OP_RECV)) begin
                    r_pkt <= w_rom_pkt;
                end
                if (w_op == OP_RECV) begin
                    r_tmo <= '0;
                end
                if (w_op == OP_WAIT) begin
                    r_wait <= w_rom_pkt[15:0];
                end
            end

            if (r_state == S_RECV && !tr_pkt_v_i) begin
                if (r_tmo == TMO_LAST) begin
                    r_timeout <= 1'b1;
                end else begin
                    r_tmo <= r_tmo + 1'b1;
                end
            end

            if (w_rsp_hs && w_mismatch) begin
                r_error <= 1'b1;
                if (r_mcount != 16'hFFFF) begin
                    r_mcount <= r_mcount + 16'd1;
                end
            end

            if ((r_state == S_WAIT) && (r_wait != 16'd0)) begin
                r_wait <= r_wait - 16'd1;
            end

            if (w_step && !w_addr_last) begin
                r_addr <= r_addr + 1'b1;
            end

            if (w_state_nxt == S_ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        tr_pkt_v_o     = (r_state == S_SEND);
        tr_pkt_ready_o = (r_state == S_RECV);
        done_o         = (r_state == S_DONE) || (r_state == S_ERROR);
    end

    assign rom_addr_o       = r_addr;
    assign tr_pkt_o         = r_pkt;
    assign error_o          = r_error;
    assign timeout_o        = r_timeout;
    assign mismatch_count_o = r_mcount;

endmodule

// File: tb/tb_bp_me_nonsynth_lce_tr_replay.sv
// Directed bench for the trace-replay engine: the bench supplies the trace ROM
// and plays the LCE side of the TR channels.
module tb_bp_me_nonsynth_lce_tr_replay;

    localparam int P   = 40;
    localparam int D   = 64;
    localparam int AW  = 4;
    localparam int TMO = 16;
    localparam int PW  = 5 + P + D;
    localparam int RW  = 4 + PW;

    localparam logic [3:0] OP_SEND = 4'h1;
    localparam logic [3:0] OP_RECV = 4'h2;
    localparam logic [3:0] OP_WAIT = 4'h3;
    localparam logic [3:0] OP_DONE = 4'h4;
    localparam logic [3:0] CMD_LD  = 4'h0;
    localparam logic [3:0] CMD_SD  = 4'h8;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          en_i = 1'b0;
    logic [AW-1:0] rom_addr_o;
    logic [RW-1:0] rom_data_i;
    logic [PW-1:0] tr_pkt_o;
    logic          tr_pkt_v_o;
    logic          tr_pkt_yumi_i = 1'b0;
    logic [PW-1:0] tr_pkt_i = '0;
    logic          tr_pkt_v_i = 1'b0;
    logic          tr_pkt_ready_o;
    logic          done_o;
    logic          error_o;
    logic          timeout_o;
    logic [15:0]   mismatch_count_o;

    logic [RW-1:0] rom [16];
    int            errors = 0;
    int            checks = 0;
    int            hs_count = 0;

    always #5 clk = ~clk;

    assign rom_data_i = rom[rom_addr_o];

    always @(posedge clk) begin
        if (tr_pkt_v_o && tr_pkt_yumi_i) hs_count <= hs_count + 1;
    end

    bp_me_nonsynth_lce_tr_replay #(
        .paddr_width_p(P),
        .dword_width_p(D),
        .rom_addr_width_p(AW),
        .timeout_p(TMO)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .en_i(en_i),
        .rom_addr_o(rom_addr_o),
        .rom_data_i(rom_data_i),
        .tr_pkt_o(tr_pkt_o),
        .tr_pkt_v_o(tr_pkt_v_o),
        .tr_pkt_yumi_i(tr_pkt_yumi_i),
        .tr_pkt_i(tr_pkt_i),
        .tr_pkt_v_i(tr_pkt_v_i),
        .tr_pkt_ready_o(tr_pkt_ready_o),
        .done_o(done_o),
        .error_o(error_o),
        .timeout_o(timeout_o),
        .mismatch_count_o(mismatch_count_o)
    );

    function automatic logic [PW-1:0] mk_pkt(input logic [3:0] cmd, input logic unc,
                                             input logic [P-1:0] paddr, input logic [D-1:0] data);
        return {cmd, unc, paddr, data};
    endfunction

    function automatic logic [RW-1:0] mk_rom(input logic [3:0] op, input logic [PW-1:0] pkt);
        return {op, pkt};
    endfunction

    task automatic fill_rom(input logic [RW-1:0] entry);
        for (int i = 0; i < 16; i++) rom[i] = entry;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        en_i = 1'b0;
        tr_pkt_yumi_i = 1'b0;
        tr_pkt_v_i = 1'b0;
        tr_pkt_i = '0;
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
    endtask

    task automatic wait_v(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tr_pkt_v_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tr_pkt_ready_o) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done_o) begin ok = 1'b1; break; end
        end
    endtask

    // Called at a negedge where valid is seen; yumi follows after 'dly' cycles.
    task automatic give_yumi(input int dly);
        repeat (dly) @(negedge clk);
        tr_pkt_yumi_i = 1'b1;
        @(negedge clk);
        tr_pkt_yumi_i = 1'b0;
    endtask

    // Called at a negedge where ready is seen.
    task automatic give_rsp(input logic [PW-1:0] pkt);
        tr_pkt_i = pkt;
        tr_pkt_v_i = 1'b1;
        @(negedge clk);
        tr_pkt_v_i = 1'b0;
    endtask

    task automatic test_reset();
        fill_rom(mk_rom(OP_SEND, mk_pkt(CMD_LD, 1'b1, 40'h1234, 64'h1)));
        reset_i = 1'b0;
        en_i = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (tr_pkt_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b exp 0", tr_pkt_v_o); end
        checks++; if (tr_pkt_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", tr_pkt_ready_o); end
        checks++; if (rom_addr_o !== 4'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", rom_addr_o); end
        checks++; if ({done_o, error_o, timeout_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {done_o, error_o, timeout_o}); end
        checks++; if (mismatch_count_o !== 16'h0) begin errors++; $display("FAIL reset_mcount: got %h exp 0", mismatch_count_o); end
        checks++; if (tr_pkt_o !== '0) begin errors++; $display("FAIL reset_pkt: got %h exp 0", tr_pkt_o); end
    endtask

    task automatic test_enable_hold();
        do_reset();
        repeat (5) @(negedge clk);
        checks++; if ({tr_pkt_v_o, rom_addr_o, done_o} !== 6'b0) begin errors++; $display("FAIL en_hold: got v=%b addr=%h done=%b exp all 0", tr_pkt_v_o, rom_addr_o, done_o); end
    endtask

    task automatic run_load(input logic [D-1:0] rsp_data, input string nm,
                            input logic [15:0] exp_mc, input logic exp_err);
        bit ok;
        int hs0;
        logic [PW-1:0] cmd_pkt;
        cmd_pkt = mk_pkt(CMD_LD, 1'b0, 40'h1000, 64'h0);
        fill_rom(mk_rom(OP_DONE, '0));
        rom[0] = mk_rom(OP_SEND, cmd_pkt);
        rom[1] = mk_rom(OP_RECV, mk_pkt(CMD_LD, 1'b0, 40'h1000, 64'hDEADBEEF));
        do_reset();
        en_i = 1'b1;
        hs0 = hs_count;
        wait_v(ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_v: got none exp valid", nm); end
        checks++; if (tr_pkt_o !== cmd_pkt) begin errors++; $display("FAIL %s_pkt: got %h exp %h", nm, tr_pkt_o, cmd_pkt); end
        give_yumi(1);
        wait_ready(ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_ready: got none exp ready", nm); end
        give_rsp(mk_pkt(CMD_LD, 1'b0, 40'h1000, rsp_data));
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s_done: got 0 exp 1", nm); end
        checks++; if (error_o !== exp_err) begin errors++; $display("FAIL %s_err: got %b exp %b", nm, error_o, exp_err); end
        checks++; if (mismatch_count_o !== exp_mc) begin errors++; $display("FAIL %s_mcount: got %0d exp %0d", nm, mismatch_count_o, exp_mc); end
        checks++; if (hs_count - hs0 !== 1) begin errors++; $display("FAIL %s_handshakes: got %0d exp 1", nm, hs_count - hs0); end
        checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL %s_timeout: got %b exp 0", nm, timeout_o); end
    endtask

    task automatic test_load_ok();
        run_load(64'hDEADBEEF, "load_ok", 16'd0, 1'b0);
    endtask

    task automatic test_load_mismatch();
        run_load(64'hDEADBEEE, "load_mm", 16'd1, 1'b1);
    endtask

    task automatic test_store();
        bit ok;
        fill_rom(mk_rom(OP_DONE, '0));
        rom[0] = mk_rom(OP_SEND, mk_pkt(CMD_SD, 1'b0, 40'h2000, 64'h55));
        rom[1] = mk_rom(OP_RECV, mk_pkt(CMD_SD, 1'b0, 40'h2000, 64'hAA));
        rom[2] = mk_rom(OP_RECV, mk_pkt(CMD_SD, 1'b0, 40'h2000, 64'h55));
        do_reset();
        en_i = 1'b1;
        wait_v(ok);
        give_yumi(0);
        wait_ready(ok);
        give_rsp(mk_pkt(CMD_SD, 1'b0, 40'h2000, 64'h55));
        @(negedge clk);
        checks++; if ({mismatch_count_o, error_o} !== 17'h0) begin errors++; $display("FAIL store_data_ignored: got mc=%0d err=%b exp 0 0", mismatch_count_o, error_o); end
        wait_ready(ok);
        give_rsp(mk_pkt(CMD_SD, 1'b0, 40'h2008, 64'h55));
        wait_done(ok);
        checks++; if (!ok) begin errors++; $display("FAIL store_done: got 0 exp 1"); end
        checks++; if ({mismatch_count_o, error_o} !== {16'd1, 1'b1}) begin errors++; $display("FAIL store_paddr: got mc=%0d err=%b exp 1 1", mismatch_count_o, error_o); end
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        fill_rom(mk_rom(OP_DONE, '0));
        rom[0] = mk_rom(OP_RECV, mk_pkt(CMD_LD, 1'b0, 40'h3000, 64'h1));
        do_reset();
        en_i = 1'b1;
        wait_ready(ok);
        n = ok ? 1 : 0;
        for (int i = 0; i < 40 && ok; i++) begin
            @(negedge clk);
            if (tr_pkt_ready_o) n++; else break;
        end
        checks++; if (n !== TMO) begin errors++; $display("FAIL tmo_cycles: got %0d exp %0d", n, TMO); end
        checks++; if ({timeout_o, error_o, done_o, tr_pkt_ready_o} !== 4'b1110) begin errors++; $display("FAIL tmo_flags: got %b exp 1110", {timeout_o, error_o, done_o, tr_pkt_ready_o}); end
        repeat (3) @(negedge clk);
        checks++; if ({done_o, tr_pkt_ready_o, rom_addr_o} !== {1'b1, 1'b0, 4'h0}) begin errors++; $display("FAIL tmo_terminal: got done=%b rdy=%b addr=%h exp 1 0 0", done_o, tr_pkt_ready_o, rom_addr_o); end
    endtask

    task automatic test_timeout_edge();
        bit ok;
        fill_rom(mk_rom(OP_DONE, '0));
        rom[0] = mk_rom(OP_RECV, mk_pkt(CMD_LD, 1'b0, 40'h3000, 64'h1));
        do_reset();
        en_i = 1'b1;
        wait_ready(ok);
        repeat (TMO - 1) @(negedge clk);
        checks++; if (tr_pkt_ready_o !== 1'b1) begin errors++; $display("FAIL tmo_edge_ready: got %b exp 1", tr_pkt_ready_o); end
        give_rsp(mk_pkt(CMD_LD, 1'b0, 40'h3000, 64'h1));
        wait_done(ok);
        checks++; if ({ok, timeout_o, error_o} !== 3'b100) begin errors++; $display("FAIL tmo_edge_flags: got done=%b tmo=%b err=%b exp 1 0 0", ok, timeout_o, error_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit stable;
        int n;
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        pa = mk_pkt(CMD_LD, 1'b1, 40'hA0, 64'h11);
        pb = mk_pkt(CMD_SD, 1'b0, 40'hB0, 64'h22);
        fill_rom(mk_rom(OP_DONE, '0));
        rom[0] = mk_rom(OP_SEND, pa);
        rom[1] = mk_rom(OP_WAIT, mk_pkt(4'h0, 1'b0, 40'h0, 64'd3));
        rom[2] = mk_rom(OP_SEND, pb);
        do_reset();
        en_i = 1'b1;
        wait_v(ok);
        stable = ok && (tr_pkt_o === pa);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (!(tr_pkt_v_o === 1'b1 && tr_pkt_o === pa)) stable = 1'b0;
        end
        @(negedge clk);
        if (!(tr_pkt_v_o === 1'b1 && tr_pkt_o === pa)) stable = 1'b0;
        checks++; if (!stable) begin errors++; $display("FAIL b2b_stable: got pkt=%h v=%b exp %h held", tr_pkt_o, tr_pkt_v_o, pa); end
        tr_pkt_yumi_i = 1'b1;
        @(posedge clk);
        #1 tr_pkt_yumi_i = 1'b0;
        checks++; if (tr_pkt_v_o !== 1'b0) begin errors++; $display("FAIL b2b_v_drop: got %b exp 0", tr_pkt_v_o); end
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (tr_pkt_v_o) begin n = i; break; end
        end
        checks++; if (n !== 6) begin errors++; $display("FAIL b2b_gap: got %0d exp 6", n); end
        checks++; if (tr_pkt_o !== pb) begin errors++; $display("FAIL b2b_pkt2: got %h exp %h", tr_pkt_o, pb); end
        @(negedge clk);
        give_yumi(0);
        wait_done(ok);
        checks++; if ({ok, error_o} !== 2'b10) begin errors++; $display("FAIL b2b_done: got done=%b err=%b exp 1 0", ok, error_o); end
    endtask

    task automatic test_reset_midsend();
        bit ok;
        logic [PW-1:0] pa;
        pa = mk_pkt(CMD_LD, 1'b0, 40'hC0, 64'h33);
        fill_rom(mk_rom(OP_DONE, '0));
        rom[0] = mk_rom(OP_WAIT, '0);
        rom[1] = mk_rom(OP_SEND, pa);
        do_reset();
        en_i = 1'b1;
        wait_v(ok);
        checks++; if ({ok, rom_addr_o} !== {1'b1, 4'h1}) begin errors++; $display("FAIL rst_mid_pre: got v=%b addr=%h exp 1 1", ok, rom_addr_o); end
        #2 reset_i = 1'b0;
        #1;
        checks++; if ({tr_pkt_v_o, rom_addr_o} !== 5'b0) begin errors++; $display("FAIL rst_mid_async: got v=%b addr=%h exp 0 0", tr_pkt_v_o, rom_addr_o); end
        @(negedge clk);
        reset_i = 1'b1;
        wait_v(ok);
        checks++; if ({ok, rom_addr_o, tr_pkt_o} !== {1'b1, 4'h1, pa}) begin errors++; $display("FAIL rst_mid_replay: got v=%b addr=%h pkt=%h exp 1 1 %h", ok, rom_addr_o, tr_pkt_o, pa); end
        give_yumi(0);
        wait_done(ok);
        checks++; if ({ok, error_o} !== 2'b10) begin errors++; $display("FAIL rst_mid_done: got done=%b err=%b exp 1 0", ok, error_o); end
    endtask

    task automatic test_bad_op();
        bit ok;
        fill_rom(mk_rom(4'h7, '0));
        do_reset();
        en_i = 1'b1;
        wait_done(ok);
        checks++; if ({ok, error_o, timeout_o, mismatch_count_o} !== {3'b110, 16'h0}) begin errors++; $display("FAIL bad_op: got done=%b err=%b tmo=%b mc=%0d exp 1 1 0 0", ok, error_o, timeout_o, mismatch_count_o); end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        fill_rom(mk_rom(OP_WAIT, '0));
        do_reset();
        en_i = 1'b1;
        wait_done(ok);
        checks++; if ({ok, error_o, rom_addr_o} !== {2'b11, 4'hF}) begin errors++; $display("FAIL addr_wrap: got done=%b err=%b addr=%h exp 1 1 f", ok, error_o, rom_addr_o); end
    endtask

    initial begin
        test_reset();
        test_enable_hold();
        test_load_ok();
        test_load_mismatch();
        test_store();
        test_timeout();
        test_timeout_edge();
        test_back_to_back();
        test_reset_midsend();
        test_bad_op();
        test_addr_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish exp finish before 200000");
        $fatal(1);
    end

endmodule
